// File: rtl/serial_bus_target_pkg.sv
// Shared types and constants for the byte-serial bus target.
package serial_bus_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CTRL,
        ST_ACCESS,
        ST_READ
    } state_e;

    localparam int CTRL_WE_BIT = 0;
    localparam int ERR_LATE    = 0;
    localparam int ERR_OVERLAP = 1;

    // Width of the slot and window counters.
    localparam int CW = 8;

endpackage

// File: rtl/serial_bus_target_shreg.sv
// NBYTES x 8 shift register: bytes enter at the top and move toward the LSB.
// A parallel load takes priority over a shift.
module byte_shift_reg #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [8*NBYTES-1:0]   load_data_i,
    input  logic                  shift_i,
    input  logic [7:0]            shift_in_i,
    output logic [8*NBYTES-1:0]   word_o
);

    localparam int W = 8 * NBYTES;

    logic [W-1:0] word_q;
    logic [W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = load_data_i;
        end else if (shift_i) begin
            word_d = W'({shift_in_i, word_q} >> 8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/serial_bus_target.sv
// Memory-side endpoint of the byte-serial pin bus: deserialises address,
// write data and control, runs one req/ack access, serialises read data.
module serial_bus_target
    import serial_bus_target_pkg::*;
#(
    parameter int NBYTES    = 4,
    parameter int GAP_SLOTS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [7:0]            addr_byte,
    input  logic [7:0]            wdata_byte,
    output logic [7:0]            rdata_byte,
    output logic                  rdata_oe,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [8*NBYTES-1:0]   mem_addr,
    output logic [8*NBYTES-1:0]   mem_wdata,
    input  logic [8*NBYTES-1:0]   mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            err,
    input  logic                  err_clr
);

    localparam int W = 8 * NBYTES;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [CW-1:0] LAST_WIN  = CW'(GAP_SLOTS - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] win_q;
    logic [CW-1:0] win_d;

    logic          cap_shift;
    logic          ctrl_cyc;
    logic          last_win;
    logic          rd_shift;
    logic          last_rd;
    logic          busy_w;

    logic          req_q;
    logic          req_d;
    logic          we_q;
    logic          we_d;
    logic          oe_q;
    logic          oe_d;
    logic [7:0]    rbyte_q;
    logic [7:0]    rbyte_d;
    logic [1:0]    err_q;
    logic [1:0]    err_d;

    logic [W-1:0]  addr_w;
    logic [W-1:0]  wdata_w;
    logic [W-1:0]  rsr_w;
    logic [W-1:0]  rd_eff;
    logic [W-1:0]  rd_shifted;
    logic          ack_hit;
    logic          rsr_load;

    byte_shift_reg #(.NBYTES(NBYTES)) u_addr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (cap_shift),
        .shift_in_i  (addr_byte),
        .word_o      (addr_w)
    );

    byte_shift_reg #(.NBYTES(NBYTES)) u_wdata (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (cap_shift),
        .shift_in_i  (wdata_byte),
        .word_o      (wdata_w)
    );

    byte_shift_reg #(.NBYTES(NBYTES)) u_rdata (
        .clk         (clk),
        .rst         (rst),
        .load_i      (rsr_load),
        .load_data_i (rd_eff),
        .shift_i     (rd_shift),
        .shift_in_i  (8'h00),
        .word_o      (rsr_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

    // The window counter runs to the end even after an early ack,
    // so every frame has the same slot timing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    cnt_d   = CW'(1);
                    state_d = (NBYTES == 1) ? ST_CTRL : ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_CTRL;
                end
            end
            ST_CTRL: begin
                win_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (win_q == LAST_WIN) begin
                    cnt_d   = '0;
                    state_d = ST_READ;
                end else begin
                    win_d = win_q + CW'(1);
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_w    = (state_q != ST_IDLE);
        cap_shift = 1'b0;
        ctrl_cyc  = 1'b0;
        last_win  = 1'b0;
        rd_shift  = 1'b0;
        last_rd   = 1'b0;
        case (state_q)
            ST_IDLE:   cap_shift = frame_start;
            ST_ADDR:   cap_shift = 1'b1;
            ST_CTRL:   ctrl_cyc  = 1'b1;
            ST_ACCESS: last_win  = (win_q == LAST_WIN);
            ST_READ: begin
                rd_shift = 1'b1;
                last_rd  = (cnt_q == LAST_BYTE);
            end
            default: ;
        endcase
    end

    // req only rises in the window, so req_q alone qualifies the ack.
    assign ack_hit    = req_q & mem_ack;
    assign rd_eff     = req_q ? (mem_ack ? mem_rdata : '0) : rsr_w;
    assign rsr_load   = ack_hit | last_win;
    assign rd_shifted = rsr_w >> 8;

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        oe_d    = oe_q;
        rbyte_d = rbyte_q;
        err_d   = err_clr ? 2'b00 : err_q;

        if (ctrl_cyc) begin
            req_d = 1'b1;
            we_d  = addr_byte[CTRL_WE_BIT];
        end
        if (ack_hit || last_win) begin
            req_d = 1'b0;
        end
        if (last_win && req_q && !mem_ack) begin
            err_d[ERR_LATE] = 1'b1;
        end
        if (frame_start && busy_w) begin
            err_d[ERR_OVERLAP] = 1'b1;
        end

        // Read byte is registered one slot ahead of the pin slot.
        if (last_win) begin
            oe_d    = ~we_q;
            rbyte_d = we_q ? 8'h00 : rd_eff[7:0];
        end else if (rd_shift) begin
            if (last_rd) begin
                oe_d    = 1'b0;
                rbyte_d = 8'h00;
            end else begin
                rbyte_d = we_q ? 8'h00 : rd_shifted[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            rbyte_q <= 8'h00;
            err_q   <= 2'b00;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            rbyte_q <= rbyte_d;
            err_q   <= err_d;
        end
    end

    assign rdata_byte = rbyte_q;
    assign rdata_oe   = oe_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_w;
    assign mem_wdata  = wdata_w;
    assign busy       = busy_w;
    assign frame_done = last_rd;
    assign err        = err_q;

endmodule

// File: tb/tb_serial_bus_target.sv
// Scoreboard bench for serial_bus_target: stimulus pushes expected accesses,
// read bytes and end-of-frame error state; a monitor pops and compares.
module tb_serial_bus_target;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [7:0]  addr_byte = 8'h00;
    logic [7:0]  wdata_byte = 8'h00;
    logic [7:0]  rdata_byte;
    logic        rdata_oe;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [1:0]  err;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    serial_bus_target dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .addr_byte  (addr_byte),
        .wdata_byte (wdata_byte),
        .rdata_byte (rdata_byte),
        .rdata_oe   (rdata_oe),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .err_clr    (err_clr)
    );

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
    } acc_t;

    acc_t       acc_q[$];
    logic [7:0] rb_q[$];
    logic [1:0] done_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    logic req_prev = 1'b0;
    acc_t       e_acc;
    logic [7:0] e_rb;
    logic [1:0] e_err;

    always @(negedge clk) begin
        if (mem_req === 1'b1 && req_prev !== 1'b1) begin
            chk("acc_pending", acc_q.size() != 0, 1'b1);
            if (acc_q.size() != 0) begin
                e_acc = acc_q.pop_front();
                chk("mem_addr", mem_addr, e_acc.a);
                chk("mem_we", mem_we, e_acc.we);
                if (e_acc.we) chk("mem_wdata", mem_wdata, e_acc.wd);
            end
        end
        if (rdata_oe === 1'b1) begin
            chk("rb_pending", rb_q.size() != 0, 1'b1);
            if (rb_q.size() != 0) begin
                e_rb = rb_q.pop_front();
                chk("rdata_byte", rdata_byte, e_rb);
            end
        end
        if (frame_done === 1'b1) begin
            chk("done_pending", done_q.size() != 0, 1'b1);
            if (done_q.size() != 0) begin
                e_err = done_q.pop_front();
                chk("err_at_done", err, e_err);
            end
        end
        req_prev = mem_req;
    end

    task automatic idle_inputs();
        frame_start = 1'b0;
        addr_byte   = 8'h00;
        wdata_byte  = 8'h00;
        mem_ack     = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] a, input logic [31:0] wd,
                             input logic [7:0] ctrl, input int ack_t,
                             input logic [31:0] rd, input int ovl_t,
                             input int clr_t, input int rst_t,
                             input logic [1:0] err_exp);
        logic        rdf;
        logic        ok;
        int          req_end;
        logic [31:0] rexp;
        rdf     = ~ctrl[0];
        ok      = (ack_t == 5) || (ack_t == 6);
        req_end = ok ? ack_t : 6;
        rexp    = ok ? rd : 32'h0;
        acc_q.push_back('{a, ctrl[0], wd});
        if (rst_t < 0) begin
            if (rdf) begin
                for (int k = 0; k < 4; k++) rb_q.push_back(rexp[8*k +: 8]);
            end
            done_q.push_back(err_exp);
        end
        for (int t = 0; t < 11; t++) begin
            frame_start = (t == 0) || (t == ovl_t);
            addr_byte   = (t < 4) ? a[8*t +: 8] : ((t == 4) ? ctrl : 8'h00);
            wdata_byte  = (t < 4) ? wd[8*t +: 8] : 8'h00;
            mem_ack     = (t == ack_t);
            mem_rdata   = rd;
            err_clr     = (t == clr_t);
            rst         = (t == rst_t);
            @(negedge clk);
            chk("req", mem_req, (t >= 5) && (t <= req_end));
            chk("busy", busy, t >= 1);
            chk("frame_done", frame_done, t == 10);
            chk("rdata_oe", rdata_oe, rdf && (t >= 7));
            if (!rdf) chk("wr_rdata_byte", rdata_byte, 8'h00);
            @(posedge clk);
            #1;
            if (t == rst_t) begin
                rst = 1'b0;
                idle_inputs();
                @(negedge clk);
                chk("rst_req", mem_req, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", frame_done, 1'b0);
                chk("rst_oe", rdata_oe, 1'b0);
                @(posedge clk);
                #1;
                return;
            end
        end
        idle_inputs();
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_oe", rdata_oe, 1'b0);
        chk("idle_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", err, 2'b00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_busy0", busy, 1'b0);
        chk("rst_err", err, 2'b00);
        chk("rst_rdata_oe", rdata_oe, 1'b0);
        chk("rst_rdata_byte", rdata_byte, 8'h00);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: read with ack at the first window slot
        run_frame(32'h12345678, 32'h0, 8'h00, 5, 32'hCAFEBABE, -1, -1, -1, 2'b00);
        // 2: write with ack at the last window slot
        run_frame(32'h00000010, 32'hDEADBEEF, 8'h01, 6, 32'h0, -1, -1, -1, 2'b00);
        // 3: late read, err_clr in the same cycle the late error is raised
        run_frame(32'hA5A50001, 32'h0, 8'h00, -1, 32'h55667788, -1, 6, -1, 2'b01);
        clear_err();
        // 4: overlapping frame_start at t3
        run_frame(32'h00001000, 32'h0, 8'h00, 6, 32'h11223344, 3, -1, -1, 2'b10);
        clear_err();
        // 5: reset during the access window, then a normal frame
        run_frame(32'h0BADF00D, 32'h0, 8'h00, -1, 32'h99999999, -1, -1, 5, 2'b00);
        chk("post_rst_err", err, 2'b00);
        // 6: back-to-back frames with one idle cycle
        run_frame(32'h00000020, 32'h0, 8'h00, 5, 32'h0A0B0C0D, -1, -1, -1, 2'b00);
        run_frame(32'h00000024, 32'h87654321, 8'hFF, 5, 32'h0, -1, -1, -1, 2'b00);
        chk("b2b_err", err, 2'b00);
        // 7: ack after the window, frame_start with frame_done
        run_frame(32'hFFFFFFFC, 32'h0, 8'hFE, 7, 32'h13579BDF, 10, -1, -1, 2'b01);
        @(negedge clk);
        chk("err_both", err, 2'b11);
        @(posedge clk);
        #1;

        repeat (2) @(posedge clk);
        #1;
        chk("acc_q_empty", acc_q.size(), 0);
        chk("rb_q_empty", rb_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
